// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception/CP0 controller: codes, CP0 map, bit positions.
package exc_defs;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CODE_W     = 5;
    localparam int unsigned CP0_ADDR_W = 8;

    // ExcCode values written into Cause
    localparam logic [CODE_W-1:0] EXC_INT  = 5'd0;
    localparam logic [CODE_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [CODE_W-1:0] EXC_ADES = 5'd5;
    localparam logic [CODE_W-1:0] EXC_SYS  = 5'd8;
    localparam logic [CODE_W-1:0] EXC_OV   = 5'd12;

    // CP0 addresses as {reg[4:0], sel[2:0]}
    localparam logic [CP0_ADDR_W-1:0] CP0_BADVADDR = {5'd8,  3'd0};
    localparam logic [CP0_ADDR_W-1:0] CP0_COUNT    = {5'd9,  3'd0};
    localparam logic [CP0_ADDR_W-1:0] CP0_COMPARE  = {5'd11, 3'd0};
    localparam logic [CP0_ADDR_W-1:0] CP0_STATUS   = {5'd12, 3'd0};
    localparam logic [CP0_ADDR_W-1:0] CP0_CAUSE    = {5'd13, 3'd0};
    localparam logic [CP0_ADDR_W-1:0] CP0_EPC      = {5'd14, 3'd0};

    // Status / Cause field positions
    localparam int unsigned STATUS_IE     = 0;
    localparam int unsigned STATUS_EXL    = 1;
    localparam int unsigned STATUS_IM7    = 15;
    localparam int unsigned CAUSE_CODE_LO = 2;
    localparam int unsigned CAUSE_IP7     = 15;
    localparam int unsigned CAUSE_TI      = 30;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Result of prioritising one retiring instruction's events
    typedef struct packed {
        logic              is_exc;
        logic              is_eret;
        logic [CODE_W-1:0] code;
        logic              use_badvaddr_pc;
    } prio_t;

    // Address-error codes are the only ones that load BadVAddr
    function automatic logic code_sets_badvaddr(input logic [CODE_W-1:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Priority encoder: picks the single event a retiring instruction raises.
module exc_prio_enc
    import exc_defs::*;
(
    input  logic  i_int_req,
    input  logic  i_fetch_error,
    input  logic  i_overflow,
    input  logic  i_syscall,
    input  logic  i_raddr_error,
    input  logic  i_waddr_error,
    input  logic  i_eret,
    output prio_t o_prio
);

    // Highest-priority flag wins; eret only when no exception is present
    always_comb begin
        o_prio = '0;
        if (i_int_req) begin
            o_prio.is_exc = 1'b1;
            o_prio.code   = EXC_INT;
        end else if (i_fetch_error) begin
            o_prio.is_exc          = 1'b1;
            o_prio.code            = EXC_ADEL;
            o_prio.use_badvaddr_pc = 1'b1;
        end else if (i_overflow) begin
            o_prio.is_exc = 1'b1;
            o_prio.code   = EXC_OV;
        end else if (i_syscall) begin
            o_prio.is_exc = 1'b1;
            o_prio.code   = EXC_SYS;
        end else if (i_raddr_error) begin
            o_prio.is_exc = 1'b1;
            o_prio.code   = EXC_ADEL;
        end else if (i_waddr_error) begin
            o_prio.is_exc = 1'b1;
            o_prio.code   = EXC_ADES;
        end else if (i_eret) begin
            o_prio.is_eret = 1'b1;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/CP0 controller beside WB: owns CP0 state, sequences flush and redirect.
module exc_ctrl
    import exc_defs::*;
#(
    parameter logic [31:0] EXC_ENTER_ADDR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES   = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wb_valid,
    input  logic [XLEN-1:0]       wb_pc,
    input  logic [XLEN-1:0]       wb_badvaddr,
    input  logic                  fetch_error,
    input  logic                  raddr_error,
    input  logic                  waddr_error,
    input  logic                  overflow,
    input  logic                  syscall,
    input  logic                  eret,
    input  logic                  mtc0,
    input  logic                  mfc0,
    input  logic [CP0_ADDR_W-1:0] cp0r_addr,
    input  logic [XLEN-1:0]       mtc0_wdata,
    output logic [XLEN-1:0]       cp0r_rdata,
    output logic                  commit,
    output logic [XLEN:0]         exc_bus,
    output logic                  cancel
);

    localparam int unsigned CNT_W = 2;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] w_flush_cnt_nxt;

    logic [XLEN-1:0]   r_count;
    logic [XLEN-1:0]   r_compare;
    logic [XLEN-1:0]   r_epc;
    logic [XLEN-1:0]   r_badvaddr;
    logic              r_ti;
    logic              r_ip7;
    logic [CODE_W-1:0] r_code;
    logic              r_im7;
    logic              r_exl;
    logic              r_ie;

    logic  w_int_req;
    prio_t w_prio;
    logic  w_accept;
    logic  w_take_exc;
    logic  w_take_eret;
    logic  w_retire;
    logic  w_wr;
    logic  w_unused;

    // Reads are purely address-driven, so the mfc0 strobe carries no information here
    assign w_unused = mfc0;

    assign w_int_req = r_ip7 & r_im7 & r_ie & ~r_exl;

    exc_prio_enc u_prio (
        .i_int_req     (w_int_req),
        .i_fetch_error (fetch_error),
        .i_overflow    (overflow),
        .i_syscall     (syscall),
        .i_raddr_error (raddr_error),
        .i_waddr_error (waddr_error),
        .i_eret        (eret),
        .o_prio        (w_prio)
    );

    assign w_accept    = wb_valid & (r_state == ST_IDLE);
    assign w_take_exc  = w_accept & w_prio.is_exc;
    assign w_take_eret = w_accept & w_prio.is_eret;
    assign w_retire    = w_accept & ~w_prio.is_exc & ~w_prio.is_eret;
    assign w_wr        = w_retire & mtc0;

    // FSM state and flush counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Next state: any redirect enters FLUSH, which counts down to IDLE
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_take_exc || w_take_eret) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: redirect and cancel start in the accept cycle, cancel lingers through the countdown
    always_comb begin
        commit  = 1'b0;
        cancel  = 1'b0;
        exc_bus = '0;
        case (r_state)
            ST_IDLE: begin
                commit = w_retire;
                if (w_take_exc) begin
                    exc_bus = {1'b1, EXC_ENTER_ADDR};
                    cancel  = 1'b1;
                end else if (w_take_eret) begin
                    exc_bus = {1'b1, r_epc};
                    cancel  = 1'b1;
                end
            end
            ST_FLUSH: cancel = (r_flush_cnt != '0);
            default: ;
        endcase
    end

    // Free-running Count and the Compare match that raises the timer interrupt
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
            r_ip7     <= 1'b0;
        end else begin
            if (w_wr && (cp0r_addr == CP0_COUNT)) begin
                r_count <= mtc0_wdata;
            end else begin
                r_count <= r_count + 32'd1;
            end
            if (w_wr && (cp0r_addr == CP0_COMPARE)) begin
                r_compare <= mtc0_wdata;
                r_ti      <= 1'b0;
                r_ip7     <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti  <= 1'b1;
                r_ip7 <= 1'b1;
            end
        end
    end

    // Exception/eret state updates and software writes to Status and EPC
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_epc      <= '0;
            r_badvaddr <= '0;
            r_code     <= '0;
            r_im7      <= 1'b0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
        end else if (w_take_exc) begin
            r_epc  <= wb_pc;
            r_code <= w_prio.code;
            r_exl  <= 1'b1;
            if (code_sets_badvaddr(w_prio.code)) begin
                r_badvaddr <= w_prio.use_badvaddr_pc ? wb_pc : wb_badvaddr;
            end
        end else if (w_take_eret) begin
            r_exl <= 1'b0;
        end else if (w_wr) begin
            case (cp0r_addr)
                CP0_STATUS: begin
                    r_im7 <= mtc0_wdata[STATUS_IM7];
                    r_exl <= mtc0_wdata[STATUS_EXL];
                    r_ie  <= mtc0_wdata[STATUS_IE];
                end
                CP0_EPC: r_epc <= mtc0_wdata;
                default: ;
            endcase
        end
    end

    // Combinational CP0 read; unmapped addresses return zero
    always_comb begin
        cp0r_rdata = '0;
        case (cp0r_addr)
            CP0_BADVADDR: cp0r_rdata = r_badvaddr;
            CP0_COUNT:    cp0r_rdata = r_count;
            CP0_COMPARE:  cp0r_rdata = r_compare;
            CP0_STATUS: begin
                cp0r_rdata[STATUS_IM7] = r_im7;
                cp0r_rdata[STATUS_EXL] = r_exl;
                cp0r_rdata[STATUS_IE]  = r_ie;
            end
            CP0_CAUSE: begin
                cp0r_rdata[CAUSE_TI]                           = r_ti;
                cp0r_rdata[CAUSE_IP7]                          = r_ip7;
                cp0r_rdata[CAUSE_CODE_LO +: CODE_W]            = r_code;
            end
            CP0_EPC:      cp0r_rdata = r_epc;
            default:      cp0r_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: one instance with a 1-cycle flush, one with a 3-cycle flush.
module tb_exc_ctrl;

    localparam logic [7:0] A_BADV   = 8'h40;
    localparam logic [7:0] A_COUNT  = 8'h48;
    localparam logic [7:0] A_CMP    = 8'h58;
    localparam logic [7:0] A_STATUS = 8'h60;
    localparam logic [7:0] A_CAUSE  = 8'h68;
    localparam logic [7:0] A_EPC    = 8'h70;

    logic        clk;
    logic        resetn;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_badvaddr;
    logic        fetch_error, raddr_error, waddr_error, overflow, syscall, eret;
    logic        mtc0, mfc0;
    logic [7:0]  cp0r_addr;
    logic [31:0] mtc0_wdata;

    logic [31:0] rdata1, rdata3;
    logic        commit1, commit3, cancel1, cancel3;
    logic [32:0] exc_bus1, exc_bus3;

    int n_cmp = 0;
    int n_bad = 0;

    exc_ctrl #(.EXC_ENTER_ADDR(32'h0000_0000), .FLUSH_CYCLES(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_badvaddr(wb_badvaddr), .fetch_error(fetch_error), .raddr_error(raddr_error),
        .waddr_error(waddr_error), .overflow(overflow), .syscall(syscall), .eret(eret),
        .mtc0(mtc0), .mfc0(mfc0), .cp0r_addr(cp0r_addr), .mtc0_wdata(mtc0_wdata),
        .cp0r_rdata(rdata1), .commit(commit1), .exc_bus(exc_bus1), .cancel(cancel1)
    );

    exc_ctrl #(.EXC_ENTER_ADDR(32'h0000_0000), .FLUSH_CYCLES(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_badvaddr(wb_badvaddr), .fetch_error(fetch_error), .raddr_error(raddr_error),
        .waddr_error(waddr_error), .overflow(overflow), .syscall(syscall), .eret(eret),
        .mtc0(mtc0), .mfc0(mfc0), .cp0r_addr(cp0r_addr), .mtc0_wdata(mtc0_wdata),
        .cp0r_rdata(rdata3), .commit(commit3), .exc_bus(exc_bus3), .cancel(cancel3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr();
        wb_valid = 1'b0; wb_pc = '0; wb_badvaddr = '0;
        fetch_error = 1'b0; raddr_error = 1'b0; waddr_error = 1'b0;
        overflow = 1'b0; syscall = 1'b0; eret = 1'b0;
        mtc0 = 1'b0; mfc0 = 1'b0; cp0r_addr = '0; mtc0_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        clr();
        repeat (n) tick();
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        cp0r_addr = a;
        #1;
        chk(tag, 64'(rdata1), 64'(exp));
    endtask

    task automatic rd3(input string tag, input logic [7:0] a, input logic [31:0] exp);
        cp0r_addr = a;
        #1;
        chk(tag, 64'(rdata3), 64'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        resetn = 1'b0;
        #12;
        chk("rst_exc_bus", 64'(exc_bus1), 64'h0);
        chk("rst_cancel",  64'(cancel1),  64'h0);
        rd("rst_status", A_STATUS, 32'h0);
        rd("rst_count",  A_COUNT,  32'h0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        // Count==Compare==0 on the first edge raises the timer
        rd("ti_after_rst", A_CAUSE, 32'h4000_8000);
        rd("count_1",      A_COUNT, 32'h1);
        clr();
        wb_valid = 1'b1; mtc0 = 1'b1; cp0r_addr = A_CMP; mtc0_wdata = 32'hFFFF_0000;
        #1;
        chk("mtc0_commit", 64'(commit1), 64'h1);
        tick(); clr();
        rd("cause_clr", A_CAUSE, 32'h0);

        // Syscall
        wb_valid = 1'b1; wb_pc = 32'h1C; syscall = 1'b1;
        #1;
        chk("sys_exc_bus", 64'(exc_bus1), 64'h1_0000_0000);
        chk("sys_cancel",  64'(cancel1),  64'h1);
        chk("sys_commit",  64'(commit1),  64'h0);
        tick(); clr();
        chk("sys_bus_1cyc",    64'(exc_bus1), 64'h0);
        chk("sys_cancel_1cyc", 64'(cancel1),  64'h0);
        rd("sys_epc",    A_EPC,    32'h1C);
        rd("sys_cause",  A_CAUSE,  32'h20);
        rd("sys_status", A_STATUS, 32'h2);
        gap(4);

        // Overflow outranks raddr_error
        wb_valid = 1'b1; wb_pc = 32'h40; overflow = 1'b1; raddr_error = 1'b1; wb_badvaddr = 32'h1003;
        tick(); clr();
        rd("ov_cause", A_CAUSE, 32'h30);
        rd("ov_badv",  A_BADV,  32'h0);
        rd("ov_epc",   A_EPC,   32'h40);
        gap(4);

        wb_valid = 1'b1; wb_pc = 32'h44; raddr_error = 1'b1; wb_badvaddr = 32'h1003;
        tick(); clr();
        rd("adel_cause", A_CAUSE, 32'h10);
        rd("adel_badv",  A_BADV,  32'h1003);
        gap(4);

        wb_valid = 1'b1; wb_pc = 32'h48; waddr_error = 1'b1; wb_badvaddr = 32'h2008;
        tick(); clr();
        rd("ades_cause", A_CAUSE, 32'h14);
        rd("ades_badv",  A_BADV,  32'h2008);
        gap(4);

        // EPC write then eret, checked on both flush lengths
        wb_valid = 1'b1; mtc0 = 1'b1; cp0r_addr = A_EPC; mtc0_wdata = 32'h1C;
        tick(); clr();
        rd("epc_wr", A_EPC, 32'h1C);
        wb_valid = 1'b1; wb_pc = 32'h200; eret = 1'b1;
        #1;
        chk("eret_bus1",    64'(exc_bus1), 64'h1_0000_001C);
        chk("eret_bus3",    64'(exc_bus3), 64'h1_0000_001C);
        chk("eret_commit",  64'(commit1),  64'h0);
        chk("eret_cancel3", 64'(cancel3),  64'h1);
        tick(); clr();
        wb_valid = 1'b1; wb_pc = 32'h300; syscall = 1'b1;
        #1;
        chk("flush_bus3",     64'(exc_bus3), 64'h0);
        chk("flush_commit3",  64'(commit3),  64'h0);
        chk("flush_cancel3a", 64'(cancel3),  64'h1);
        chk("flush_bus1",     64'(exc_bus1), 64'h0);
        tick(); clr();
        chk("flush_cancel3b", 64'(cancel3), 64'h1);
        rd("eret_status", A_STATUS, 32'h0);
        tick();
        chk("flush_cancel3c", 64'(cancel3), 64'h0);
        rd3("eret_epc3",    A_EPC,    32'h1C);
        rd3("eret_status3", A_STATUS, 32'h0);
        gap(2);

        // mtc0 Status on a faulting fetch is dropped
        wb_valid = 1'b1; wb_pc = 32'h500; fetch_error = 1'b1;
        mtc0 = 1'b1; cp0r_addr = A_STATUS; mtc0_wdata = 32'h8001;
        #1;
        chk("fe_bus",    64'(exc_bus1), 64'h1_0000_0000);
        chk("fe_commit", 64'(commit1),  64'h0);
        tick(); clr();
        rd("fe_status", A_STATUS, 32'h2);
        rd("fe_cause",  A_CAUSE,  32'h10);
        rd("fe_badv",   A_BADV,   32'h500);
        gap(4);

        // Asynchronous reset in the middle of a flush
        wb_valid = 1'b1; wb_pc = 32'h600; syscall = 1'b1;
        tick(); clr();
        #1;
        chk("pre_rst_cancel3", 64'(cancel3), 64'h1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_cancel3", 64'(cancel3), 64'h0);
        chk("mid_rst_cancel1", 64'(cancel1), 64'h0);
        rd("mid_rst_epc",    A_EPC,    32'h0);
        rd("mid_rst_status", A_STATUS, 32'h0);
        rd3("mid_rst_epc3",  A_EPC,    32'h0);

        // Timer: Compare written on the same edge Count matches it, clear wins
        @(negedge clk);
        wb_valid = 1'b1; mtc0 = 1'b1; cp0r_addr = A_CMP; mtc0_wdata = 32'h5;
        resetn = 1'b1;
        tick(); clr();
        rd("clr_wins", A_CAUSE, 32'h0);
        clr();
        wb_valid = 1'b1; mtc0 = 1'b1; cp0r_addr = A_COUNT; mtc0_wdata = 32'h0;
        tick(); clr();
        wb_valid = 1'b1; mtc0 = 1'b1; cp0r_addr = A_STATUS; mtc0_wdata = 32'h8001;
        tick(); clr();
        rd("tmr_count1", A_COUNT, 32'h1);
        clr();
        repeat (4) tick();
        rd("tmr_count5", A_COUNT, 32'h5);
        rd("tmr_pre_ti", A_CAUSE, 32'h0);
        clr();
        tick();
        rd("tmr_ti", A_CAUSE, 32'h4000_8000);
        clr();
        wb_valid = 1'b1; wb_pc = 32'h80;
        #1;
        chk("int_bus",    64'(exc_bus1), 64'h1_0000_0000);
        chk("int_commit", 64'(commit1),  64'h0);
        tick(); clr();
        rd("int_cause",  A_CAUSE,  32'h4000_8000);
        rd("int_epc",    A_EPC,    32'h80);
        rd("int_status", A_STATUS, 32'h8003);
        clr();
        tick();
        wb_valid = 1'b1; mtc0 = 1'b1; cp0r_addr = A_CMP; mtc0_wdata = 32'd100;
        #1;
        chk("cmp_commit", 64'(commit1), 64'h1);
        tick(); clr();
        rd("cmp_clr_ti", A_CAUSE, 32'h0);

        // Back-to-back plain instructions, reading Count on each
        clr();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1; wb_pc = 32'h1000 + 32'(4 * i);
            mfc0 = 1'b1; cp0r_addr = A_COUNT;
            #1;
            chk("b2b_commit", 64'(commit1), 64'h1);
            chk("b2b_count",  64'(rdata1),  64'(i + 1));
            tick();
        end
        clr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Central exception/CP0 controller for the 5-stage pipeline, sitting beside the writeback stage.
- Receives per-instruction exception flags and CP0 move requests from WB.
- Prioritises one event per retiring instruction and owns the CP0 registers: Status, Cause, EPC, BadVAddr, Count, Compare.
- Sequences the pipeline flush and redirect through a small FSM; also raises the timer interrupt.

Parameters:
- EXC_ENTER_ADDR, 32'h0000_0000, exception/interrupt entry PC.
- FLUSH_CYCLES, 1, cycles cancel is held after a redirect; legal range 1..4.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- wb_valid  in  1  WB holds a retiring instruction this cycle
- wb_pc  in  32  PC of that instruction
- wb_badvaddr  in  32  faulting data address (valid with raddr_error/waddr_error)
- fetch_error, raddr_error, waddr_error, overflow, syscall, eret  in  1 each  exception/return flags from WB
- mtc0, mfc0  in  1 each  CP0 move
- cp0r_addr  in  8  {reg[4:0], sel[2:0]}
- mtc0_wdata  in  32  data for mtc0
- cp0r_rdata  out  32  combinational read of cp0r_addr
- commit  out  1  instruction may write regfile/HI/LO
- exc_bus  out  33  {exc_valid, exc_pc}
- cancel  out  1  kill all younger in-flight instructions

Behaviour:
- Reset (async): FSM=IDLE; every CP0 field 0; exc_bus=0; cancel=0.
- CP0 map (sel 0):
  - 8 BadVAddr
  - 9 Count (+1 every cycle, wraps at 2^32)
  - 11 Compare
  - 12 Status {IM7 bit15, EXL bit1, IE bit0}
  - 13 Cause {TI bit30, IP7 bit15, ExcCode bits6:2}
  - 14 EPC
- Unmapped registers read 0; writes to them are ignored.
- Timer: when Count==Compare, set TI and IP7. A mtc0 to Compare clears TI/IP7. Set and clear in the same cycle: clear wins.
- Interrupt pending: int_req = IP7 & IM7 & IE & ~EXL.
- Event accepted only when FSM=IDLE and wb_valid=1.
- Event priority, high to low, with ExcCode:
  - interrupt, 0
  - fetch_error, 4, BadVAddr<=wb_pc
  - overflow, 12
  - syscall, 8
  - raddr_error, 4, BadVAddr<=wb_badvaddr
  - waddr_error, 5, BadVAddr<=wb_badvaddr
  - eret (not an exception)
- On an exception:
  - EPC<=wb_pc; ExcCode<=code; EXL<=1.
  - exc_bus={1,EXC_ENTER_ADDR} for exactly one cycle (combinational in the accept cycle).
  - mtc0 on the same instruction is suppressed; commit=0.
- On eret: exc_bus={1,EPC}; EXL<=0; commit=0.
- Otherwise: commit=wb_valid&IDLE; mtc0 writes take effect at the clock edge. Status writes only IM7/EXL/IE; Cause and BadVAddr are read-only to software.
- cancel is asserted in the accept cycle and stays high for FLUSH_CYCLES total cycles.
- FSM:
  - IDLE -> FLUSH on any exception or eret, loading flush counter = FLUSH_CYCLES-1.
  - FLUSH decrements the counter and returns to IDLE at 0.
  - FLUSH_CYCLES=1 returns to IDLE next cycle.
  - In FLUSH, wb_valid is ignored: commit=0, no CP0 update, no new event.
- mfc0 in the same cycle as a Count increment returns the pre-increment value.
- Reset asserted mid-FLUSH: immediately IDLE, cancel=0.

Decomposition:
- Shared package exc_defs:
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_OV=12
  - CP0 address constants {reg, sel}
  - Status/Cause bit positions
- One sub-module, exc_prio_enc: combinational priority encoder from flags plus int_req to {is_exc, is_eret, code, use_badvaddr_pc}.
- Registers and FSM stay in exc_ctrl.

Test Plan:
- Syscall at wb_pc=0x1C -> exc_bus=33'h1_0000_0000 for one cycle; then EPC=0x1C, Cause=0x20, Status=0x2; cancel high 1 cycle; commit=0.
- overflow+raddr_error together, pc 0x40, addr 0x1003 -> ExcCode=12, BadVAddr unchanged. raddr_error alone -> Cause=0x10, BadVAddr=0x1003.
- EPC=0x1C, then eret -> exc_bus={1,0x1C}; EXL=0. Same test with FLUSH_CYCLES=3: cancel high 3 cycles, and a wb_valid syscall in flush cycle 2 is ignored.
- mtc0 Compare=5, Status=0x8001 -> TI set when Count reaches 5; next wb_valid at pc 0x80 takes Int: Cause=0x4000_8000, EPC=0x80. Then mtc0 Compare=100 clears TI.
- mtc0 Status plus fetch_error on the same instruction -> Status.EXL=1 only; the mtc0 data is not written.
- resetn low during FLUSH -> cancel=0 and all CP0 registers 0 without a clock edge. Back-to-back retiring instructions with no flags -> commit=1 each cycle.
